// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package mul_pkg;

   localparam int WIDTH_DEF = 32;

   function automatic int cnt_width(input int width);
      return $clog2(width / 2 + 2);
   endfunction

   localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   typedef enum logic [2:0] {
      ZERO   = 3'd0,
      PLUS1  = 3'd1,
      PLUS2  = 3'd2,
      MINUS1 = 3'd3,
      MINUS2 = 3'd4
   } booth_op_e;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: bit-pair triplet {q[2i+1], q[2i], q[2i-1]} to a partial-product selector.
module booth_recoder
   import mul_pkg::*;
(
   input  logic [2:0] triplet,
   output booth_op_e  op
);

   // Combinational triplet decode
   always_comb begin
      op = ZERO;
      case (triplet)
         3'b000:  op = ZERO;
         3'b001:  op = PLUS1;
         3'b010:  op = PLUS1;
         3'b011:  op = PLUS2;
         3'b100:  op = MINUS2;
         3'b101:  op = MINUS1;
         3'b110:  op = MINUS1;
         3'b111:  op = ZERO;
         default: op = ZERO;
      endcase
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier, one bit pair per clock, start/busy/done handshake.
// Optional unsigned mode when MUL_UNSIGNED_EN is defined (adds port is_unsigned).
module booth_mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
)
(
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
`ifdef MUL_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] zhigh,
   output logic [WIDTH-1:0] zlow
);

`ifdef MUL_UNSIGNED_EN
   // Unsigned operands need two extra magnitude bits and one extra bit pair.
   localparam int XW = 2;
`else
   localparam int XW = 0;
`endif
   localparam int ITER  = WIDTH / 2;
   localparam int CNT_W = cnt_width(WIDTH);
   localparam int ACC_W = WIDTH + 2 + XW;
   localparam int OPW   = WIDTH + XW;
   localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   mul_state_e       state_r;
   logic [ACC_W-1:0] m_r;
   logic [ACC_W-1:0] acc_r;
   logic [OPW-1:0]   q_r;
   logic [OPW-1:0]   lo_r;
   logic             q_m1_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_last_r;
   logic             unsigned_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] zhigh_r;
   logic [WIDTH-1:0] zlow_r;

   logic             sign_ext_s;
   logic [ACC_W-1:0] m_load_s;
   logic [OPW-1:0]   q_load_s;
   logic [CNT_W-1:0] cnt_last_load_s;
   booth_op_e        op_s;
   logic [ACC_W-1:0] partial_s;
   logic [ACC_W-1:0] sum_s;
   logic [ACC_W-1:0] acc_next_s;
   logic [OPW-1:0]   lo_next_s;
   logic [WIDTH-1:0] prod_hi_s;
   logic [WIDTH-1:0] prod_lo_s;

   booth_recoder u_recoder (
      .triplet ({q_r[1], q_r[0], q_m1_r}),
      .op      (op_s)
   );

   // Operand extension and iteration count selected at launch
   always_comb begin
`ifdef MUL_UNSIGNED_EN
      sign_ext_s      = ~is_unsigned;
      cnt_last_load_s = is_unsigned ? CNT_W'(ITER) : CNT_W'(ITER - 1);
`else
      sign_ext_s      = 1'b1;
      cnt_last_load_s = CNT_W'(ITER - 1);
`endif
      if (sign_ext_s) begin
         m_load_s = ACC_W'($signed(multiplicand));
         q_load_s = OPW'($signed(multiplier));
      end else begin
         m_load_s = ACC_W'(multiplicand);
         q_load_s = OPW'(multiplier);
      end
   end

   // One Booth step: add the selected partial, then arithmetic shift the pair out into lo
   always_comb begin
      partial_s = '0;
      case (op_s)
         ZERO:    partial_s = '0;
         PLUS1:   partial_s = m_r;
         PLUS2:   partial_s = m_r << 2'd1;
         MINUS1:  partial_s = ~m_r + ACC_ONE;
         MINUS2:  partial_s = ~(m_r << 2'd1) + ACC_ONE;
         default: partial_s = '0;
      endcase
      sum_s      = acc_r + partial_s;
      acc_next_s = ACC_W'($signed(sum_s) >>> 2'd2);
      lo_next_s  = {sum_s[1:0], lo_r[OPW-1:2]};
   end

   // Final product alignment; signed runs in a widened build leave two stale bits at the bottom of lo
   always_comb begin
`ifdef MUL_UNSIGNED_EN
      if (unsigned_r) begin
         prod_hi_s = {acc_next_s[WIDTH-3:0], lo_next_s[WIDTH+1:WIDTH]};
         prod_lo_s = lo_next_s[WIDTH-1:0];
      end else begin
         prod_hi_s = acc_next_s[WIDTH-1:0];
         prod_lo_s = lo_next_s[WIDTH+1:2];
      end
`else
      prod_hi_s = acc_next_s[WIDTH-1:0];
      prod_lo_s = lo_next_s;
`endif
   end

   // Control FSM and datapath registers
   always_ff @(posedge clock) begin
      if (clear) begin
         state_r    <= IDLE;
         m_r        <= '0;
         acc_r      <= '0;
         q_r        <= '0;
         lo_r       <= '0;
         q_m1_r     <= 1'b0;
         cnt_r      <= '0;
         cnt_last_r <= '0;
         unsigned_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         zhigh_r    <= '0;
         zlow_r     <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  m_r        <= m_load_s;
                  q_r        <= q_load_s;
                  q_m1_r     <= 1'b0;
                  acc_r      <= '0;
                  lo_r       <= '0;
                  cnt_r      <= '0;
                  cnt_last_r <= cnt_last_load_s;
                  unsigned_r <= ~sign_ext_s;
                  busy_r     <= 1'b1;
                  state_r    <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               acc_r  <= acc_next_s;
               lo_r   <= lo_next_s;
               q_r    <= q_r >> 2'd2;
               q_m1_r <= q_r[1];
               cnt_r  <= cnt_r + CNT_ONE;
               if (cnt_r == cnt_last_r) begin
                  zhigh_r <= prod_hi_s;
                  zlow_r  <= prod_lo_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign zhigh = zhigh_r;
   assign zlow  = zlow_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed corners plus a randomized sweep against an arithmetic model.
module tb_booth_mul_seq;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        is_unsigned_v;
   logic        busy;
   logic        done;
   logic [31:0] zhigh;
   logic [31:0] zlow;

   typedef struct {
      logic [63:0] prod;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   booth_mul_seq #(.WIDTH(32)) dut (
      .clock        (clock),
      .clear        (clear),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
`ifdef MUL_UNSIGNED_EN
      .is_unsigned  (is_unsigned_v),
`endif
      .busy         (busy),
      .done         (done),
      .zhigh        (zhigh),
      .zlow         (zlow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q, input bit uns);
      longint sm;
      longint sq;
      if (uns) return {32'h0, m} * {32'h0, q};
      sm = longint'($signed(m));
      sq = longint'($signed(q));
      return 64'(sm * sq);
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compare each done pulse against the oldest expected result
   initial begin
      int  busy_cnt  = 0;
      bit  prev_done = 1'b0;
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (clear) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               if (prev_done) chk("done_width", 64'(prev_done), 64'(0));
               if (sb.size() == 0) begin
                  chk("unexpected_done", 64'(done), 64'(0));
               end else begin
                  e = sb.pop_front();
                  chk("zhigh", 64'(zhigh), 64'(e.prod[63:32]));
                  chk("zlow", 64'(zlow), 64'(e.prod[31:0]));
                  chk("busy_cycles", 64'(busy_cnt), 64'(e.cyc));
               end
               busy_cnt = 0;
            end
         end
         prev_done = done;
      end
   end

   task automatic launch(input logic [31:0] m, input logic [31:0] q, input bit uns, input bit push);
      exp_t e;
      @(negedge clock);
      multiplicand  = m;
      multiplier    = q;
      is_unsigned_v = uns;
      start         = 1'b1;
      if (push) begin
         e.prod = ref_prod(m, q, uns);
         e.cyc  = uns ? 17 : 16;
         sb.push_back(e);
      end
      @(negedge clock);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; optionally pulse start during the DONE cycle
   task automatic wait_done(input bit poke_in_done);
      bit got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("done_timeout", 64'(got), 64'(1));
      if (poke_in_done) begin
         @(negedge clock);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end else begin
         @(posedge clock);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bit          uns;
      logic [31:0] m;
      logic [31:0] q;
      exp_t        e;
      int          ndone;

      clear = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0; is_unsigned_v = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_zhigh", 64'(zhigh), 64'(0));
      chk("rst_zlow", 64'(zlow), 64'(0));
      @(negedge clock);
      clear = 1'b0;

      // Directed: small values, -1*1, most-negative squared
      launch(32'h0000_0024, 32'h0000_0026, 1'b0, 1'b1);
      wait_done(1'b0);
      chk("dir_0x558", 64'({zhigh, zlow}), 64'h0000_0000_0000_0558);
      launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      wait_done(1'b0);
      launch(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      wait_done(1'b0);
      chk("dir_min_sq", 64'({zhigh, zlow}), 64'h4000_0000_0000_0000);

      // Abort at the 8th RUN cycle: no done, outputs cleared
      launch(32'h1234_5678, 32'h0000_0003, 1'b0, 1'b0);
      repeat (7) @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_z", 64'({zhigh, zlow}), 64'(0));
      @(negedge clock);
      clear = 1'b0;
      launch(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b1);
      wait_done(1'b0);
      chk("dir_7xm3", 64'({zhigh, zlow}), 64'hFFFF_FFFF_FFFF_FFEB);

      // Operand changes and start pulses during RUN and DONE are ignored
      launch(32'h0000_1234, 32'hFFFF_FFFB, 1'b0, 1'b1);
      repeat (4) @(negedge clock);
      multiplicand = 32'hDEAD_BEEF;
      multiplier   = 32'h7654_3210;
      start        = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(1'b1);
      repeat (3) @(posedge clock);
      #1;
      chk("no_relaunch_busy", 64'(busy), 64'(0));

      // start held high relaunches on every IDLE visit
      @(negedge clock);
      multiplicand  = 32'hFFFF_FF00;
      multiplier    = 32'h0001_0001;
      is_unsigned_v = 1'b0;
      start         = 1'b1;
      e.prod = ref_prod(32'hFFFF_FF00, 32'h0001_0001, 1'b0);
      e.cyc  = 16;
      sb.push_back(e);
      sb.push_back(e);
      ndone = 0;
      for (int i = 0; i < 60 && ndone < 2; i++) begin
         @(posedge clock);
         #1;
         if (done) ndone++;
      end
      chk("held_start_dones", 64'(ndone), 64'(2));
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);

`ifdef MUL_UNSIGNED_EN
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
      wait_done(1'b0);
      chk("uns_max_sq", 64'({zhigh, zlow}), 64'hFFFF_FFFE_0000_0001);
`endif

      // Randomized sweep
      for (int n = 0; n < 1000; n++) begin
         m = pick_operand();
         q = pick_operand();
`ifdef MUL_UNSIGNED_EN
         uns = 1'($urandom_range(0, 1));
`else
         uns = 1'b0;
`endif
         launch(m, q, uns, 1'b1);
         wait_done(1'b0);
      end

      repeat (3) @(posedge clock);
      #1;
      chk("sb_drain", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
